alu_exec_sequencer: RTL and testbench

//  Execute-stage controller that sequences the shared ALU for one decoded instruction at a time.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_exec_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_exec_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execute sequencer.
// Holds the ALU control codes, the decoded opcode constants and the sequencer state encoding.
package alu_seq_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND0  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_ALU3  = 4'b1000;
  localparam logic [3:0] ALU_LSL   = 4'b1001;
  localparam logic [3:0] ALU_LSR   = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1111;

  // Instruction[31:21] values recognised when alu_op == 2'b10
  localparam logic [10:0] OP_ADDS  = 11'd1368;
  localparam logic [10:0] OP_SUBS  = 11'd1880;
  localparam logic [10:0] OP_LSL   = 11'd1691;
  localparam logic [10:0] OP_LSR   = 11'd1690;
  localparam logic [10:0] OP_ADDI0 = 11'd1160;
  localparam logic [10:0] OP_ADDI1 = 11'd1161;
  localparam logic [10:0] OP_STUR  = 11'd1984;
  localparam logic [10:0] OP_LDUR  = 11'd1986;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift,
    StHold
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decoder from {alu_op, opcode} to the ALU control code plus qualifiers.
// Ports:
//   alu_op    in   2   ALUOp from main control
//   opcode    in   11  instruction[31:21]
//   code      out  4   ALU control code
//   is_shift  out  1   LSL/LSR: run as iterated 1-bit shifter passes
//   set_flags out  1   ADDS/SUBS: write NZCV
//   illegal   out  1   alu_op == 10 with an unrecognised opcode
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  code,
  output logic        is_shift,
  output logic        set_flags,
  output logic        illegal
);

  always_comb begin
    code      = ALU_AND0;
    is_shift  = 1'b0;
    set_flags = 1'b0;
    illegal   = 1'b0;
    unique case (alu_op)
      2'b00: code = ALU_AND0;
      2'b01: code = ALU_PASSB;
      2'b11: code = ALU_ALU3;
      2'b10: begin
        case (opcode)
          OP_ADDS: begin
            code      = ALU_ADD;
            set_flags = 1'b1;
          end
          OP_SUBS: begin
            code      = ALU_SUB;
            set_flags = 1'b1;
          end
          OP_LSL: begin
            code     = ALU_LSL;
            is_shift = 1'b1;
          end
          OP_LSR: begin
            code     = ALU_LSR;
            is_shift = 1'b1;
          end
          OP_ADDI0, OP_ADDI1, OP_STUR, OP_LDUR: code = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      default: code = ALU_AND0;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage controller: sequences the shared ALU for one decoded instruction at a time.
// Single-pass ops take one EXEC cycle; LSL/LSR run as shamt 1-bit passes that feed the
// previous ALU result back into operand A. The result is then held for writeback.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     handshake from decode
//   opcode, alu_op, shamt instruction fields, captured at acceptance
//   alu_ctrl, fb_sel      ALU control code and operand-A feedback select
//   res_we, flag_we       result / NZCV write enables
//   out_valid/out_ready   handshake to writeback; illegal qualifies out_valid
// All outputs are registered and computed alongside the next state.
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        opcode,
  input  logic [1:0]         alu_op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [3:0]         alu_ctrl,
  output logic               fb_sel,
  output logic               res_we,
  output logic               flag_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               illegal
);

  localparam logic [SHAMT_W-1:0] CountOne = SHAMT_W'(1);

  logic [3:0] dec_code;
  logic       dec_is_shift;
  logic       dec_set_flags;
  logic       dec_illegal;

  alu_op_decode u_decode (
    .alu_op    (alu_op),
    .opcode    (opcode),
    .code      (dec_code),
    .is_shift  (dec_is_shift),
    .set_flags (dec_set_flags),
    .illegal   (dec_illegal)
  );

  seq_state_e         state_q;
  logic [SHAMT_W-1:0] count_q;
  logic [3:0]         code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      code_q    <= ALU_AND0;
      in_ready  <= 1'b0;
      alu_ctrl  <= ALU_AND0;
      fb_sel    <= 1'b0;
      res_we    <= 1'b0;
      flag_we   <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // ALU strobes are single-cycle unless re-asserted below
      alu_ctrl <= ALU_AND0;
      fb_sel   <= 1'b0;
      res_we   <= 1'b0;
      flag_we  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            code_q   <= dec_code;
            if (dec_illegal) begin
              state_q   <= StHold;
              out_valid <= 1'b1;
              illegal   <= 1'b1;
            end else if (dec_is_shift) begin
              state_q  <= StShift;
              count_q  <= shamt;
              res_we   <= 1'b1;
              // A zero shift still needs one pass to move A into the result register
              alu_ctrl <= (shamt == '0) ? ALU_PASSA : dec_code;
            end else begin
              state_q  <= StExec;
              res_we   <= 1'b1;
              alu_ctrl <= dec_code;
              flag_we  <= dec_set_flags;
            end
          end
        end
        StExec: begin
          state_q   <= StHold;
          out_valid <= 1'b1;
        end
        StShift: begin
          // count_q is the number of passes still including the current one
          if (count_q > CountOne) begin
            count_q  <= count_q - CountOne;
            res_we   <= 1'b1;
            fb_sel   <= 1'b1;
            alu_ctrl <= code_q;
          end else begin
            state_q   <= StHold;
            count_q   <= '0;
            out_valid <= 1'b1;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: table of directed instructions with hand-computed
// codes, pass counts and latencies, plus hand sequences for HOLD back-pressure and mid-shift reset.
module tb_alu_exec_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic [5:0]  shamt;
  logic [3:0]  alu_ctrl;
  logic        fb_sel;
  logic        res_we;
  logic        flag_we;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;

  int n_cmp;
  int n_bad;

  alu_exec_sequencer #(
    .SHAMT_W (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .alu_op    (alu_op),
    .shamt     (shamt),
    .alu_ctrl  (alu_ctrl),
    .fb_sel    (fb_sel),
    .res_we    (res_we),
    .flag_we   (flag_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [5:0]  shamt;
    logic [3:0]  exp_code;
    logic        exp_flags;
    logic        exp_ill;
    int          exp_passes;
    int          exp_lat;
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      if (in_ready === 1'b1) break;
      tick();
    end
    if (k == 20) check("wait_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int passes;
    wait_ready();
    alu_op   = v.alu_op;
    opcode   = v.opcode;
    shamt    = v.shamt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    passes   = 0;
    for (int k = 1; k <= 80; k++) begin
      check("in_ready_busy", in_ready, 0);
      if (res_we === 1'b1) begin
        check("pass_alu_ctrl", alu_ctrl, v.exp_code);
        check("pass_fb_sel", fb_sel, passes > 0);
        check("pass_flag_we", flag_we, v.exp_flags);
        passes++;
      end
      if (out_valid === 1'b1) begin
        lat = k;
        check("hold_illegal", illegal, v.exp_ill);
        check("hold_alu_ctrl", alu_ctrl, 0);
        check("hold_res_we", res_we, 0);
        check("hold_flag_we", flag_we, 0);
        break;
      end
      tick();
    end
    check("latency", lat, v.exp_lat);
    check("res_we_pulses", passes, v.exp_passes);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_illegal", illegal, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //           alu_op  opcode     shamt  code     flg   ill   passes lat
    vecs[0]  = '{2'b10, 11'd1368, 6'd0,  4'b0010, 1'b1, 1'b0, 1,  2};   // ADDS
    vecs[1]  = '{2'b10, 11'd1880, 6'd0,  4'b0011, 1'b1, 1'b0, 1,  2};   // SUBS
    vecs[2]  = '{2'b10, 11'd1691, 6'd3,  4'b1001, 1'b0, 1'b0, 3,  4};   // LSL #3
    vecs[3]  = '{2'b10, 11'd1690, 6'd0,  4'b1111, 1'b0, 1'b0, 1,  2};   // LSR #0 -> PASS_A
    vecs[4]  = '{2'b10, 11'd1690, 6'd63, 4'b1010, 1'b0, 1'b0, 63, 64};  // LSR #63
    vecs[5]  = '{2'b10, 11'd1160, 6'd0,  4'b0010, 1'b0, 1'b0, 1,  2};   // ADDI
    vecs[6]  = '{2'b10, 11'd1161, 6'd7,  4'b0010, 1'b0, 1'b0, 1,  2};   // ADDI, shamt ignored
    vecs[7]  = '{2'b10, 11'd1984, 6'd0,  4'b0010, 1'b0, 1'b0, 1,  2};   // STUR
    vecs[8]  = '{2'b10, 11'd1986, 6'd0,  4'b0010, 1'b0, 1'b0, 1,  2};   // LDUR
    vecs[9]  = '{2'b00, 11'd1691, 6'd5,  4'b0000, 1'b0, 1'b0, 1,  2};   // alu_op 00, not a shift
    vecs[10] = '{2'b01, 11'd123,  6'd0,  4'b0111, 1'b0, 1'b0, 1,  2};   // alu_op 01
    vecs[11] = '{2'b11, 11'd1368, 6'd0,  4'b1000, 1'b0, 1'b0, 1,  2};   // alu_op 11, no flags
    vecs[12] = '{2'b10, 11'd1000, 6'd0,  4'b0000, 1'b0, 1'b1, 0,  1};   // illegal
    vecs[13] = '{2'b10, 11'd1692, 6'd2,  4'b0000, 1'b0, 1'b1, 0,  1};   // illegal near LSL
    vecs[14] = '{2'b10, 11'd1691, 6'd1,  4'b1001, 1'b0, 1'b0, 1,  2};   // LSL #1
    vecs[15] = '{2'b10, 11'd1690, 6'd2,  4'b1010, 1'b0, 1'b0, 2,  3};   // LSR #2

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    alu_op    = '0;
    shamt     = '0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_fb_sel", fb_sel, 0);
    check("rst_res_we", res_we, 0);
    check("rst_flag_we", flag_we, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b1;
    #2;
    check("post_rst_in_ready_low", in_ready, 0);
    tick();
    check("post_rst_in_ready_high", in_ready, 1);

    for (int i = 0; i < NumVec; i++) run_vec(vecs[i]);

    // HOLD back-pressure with a competing request on the input
    wait_ready();
    alu_op   = 2'b10;
    opcode   = 11'd1000;
    in_valid = 1'b1;
    tick();
    opcode = 11'd1368;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_illegal", illegal, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_res_we", res_we, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_rel_out_valid", out_valid, 0);
    check("stall_rel_in_ready", in_ready, 1);
    check("stall_rel_res_we", res_we, 0);
    tick();
    check("stall_next_res_we", res_we, 1);
    check("stall_next_alu_ctrl", alu_ctrl, 4'b0010);
    check("stall_next_flag_we", flag_we, 1);
    check("stall_next_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    check("stall_next_out_valid", out_valid, 1);
    check("stall_next_illegal", illegal, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_done_out_valid", out_valid, 0);

    // Reset in the middle of a 12-pass shift, on the pass with count 10
    wait_ready();
    alu_op   = 2'b10;
    opcode   = 11'd1691;
    shamt    = 6'd12;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midshift_res_we", res_we, 1);
    check("midshift_fb_sel", fb_sel, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_alu_ctrl", alu_ctrl, 0);
    check("abort_fb_sel", fb_sel, 0);
    check("abort_res_we", res_we, 0);
    check("abort_flag_we", flag_we, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_illegal", illegal, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("abort_rel_in_ready", in_ready, 1);
    check("abort_rel_out_valid", out_valid, 0);
    check("abort_rel_res_we", res_we, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet_out_valid", out_valid, 0);
      check("abort_quiet_res_we", res_we, 0);
    end
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
